// File: rtl/shift_right_piso_pkg.sv
// Shared types and helpers for the shift-right PISO transmitter.
// Provides the FSM state type and the bit-counter width helper.
package shift_right_piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // The counter must span 0..width-1 and can never be narrower than one bit.
    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_right_piso.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and
// shifts it out LSB first, streaming back-to-back words without a gap.
module shift_right_piso
    import shift_right_piso_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] parallel_data_in,
    output logic             load_ready,
    output logic             serial_data_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             done
);

    localparam int             CNT_W    = count_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;
    logic             at_last_s;
    logic             load_ready_s;
    logic             accept_s;

    // Handshake and next-state decode; a new word may enter on the last bit.
    always_comb begin
        at_last_s    = 1'b0;
        load_ready_s = 1'b0;
        accept_s     = 1'b0;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                load_ready_s = 1'b1;
                accept_s     = load_valid;
                if (accept_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                at_last_s    = (cnt_r == LAST_CNT);
                load_ready_s = at_last_s;
                accept_s     = load_valid & at_last_s;
                if (at_last_s && !accept_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shift register: load on accept, otherwise shift right with zero fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            shreg_r <= parallel_data_in;
        end else if (state_r == ST_SHIFT) begin
            shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // Bit counter wraps to zero at end of word so it never exceeds WIDTH-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_SHIFT) && !at_last_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // One-cycle done pulse following the last bit of each word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= at_last_s;
        end
    end

    assign load_ready      = load_ready_s;
    assign serial_valid    = (state_r == ST_SHIFT);
    assign serial_data_out = (state_r == ST_SHIFT) ? shreg_r[0] : IDLE_LEVEL;
    assign last_bit        = at_last_s;
    assign done            = done_r;

endmodule

// File: doc/shift_right_piso.md
Name: shift_right_piso

Overview:
Parallel-in serial-out transmitter, the sending end of the team's shift-right SIPO link. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out LSB first, one bit per clk, with a serial_valid qualifier. A shift-right SIPO capturing while serial_valid is high holds the original word after WIDTH bits. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word length in bits; legal range is 2 and up.
IDLE_LEVEL, 1'b0, serial_data_out level while no word is being shifted.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load_valid  input  1  parallel_data_in holds a word to send
parallel_data_in  input  WIDTH  word to transmit; bit 0 is sent first
load_ready  output  1  block accepts a word this cycle
serial_data_out  output  1  current serial bit
serial_valid  output  1  serial_data_out carries a valid data bit
last_bit  output  1  current bit is bit WIDTH-1 of the word
done  output  1  one-cycle pulse, registered, in the cycle after the last bit of a word

Behaviour:
- Reset is asynchronous and active-high. Reset takes effect immediately, independent of clk.
- Reset values:
  - state = IDLE; shift register = 0; bit count = 0.
  - serial_valid = 0, last_bit = 0, done = 0, serial_data_out = IDLE_LEVEL, load_ready = 1 once reset is released.
- State machine has two states, IDLE and SHIFT.
- load_ready is combinational: 1 in IDLE, and 1 in SHIFT when bit count = WIDTH-1; otherwise 0.
- accept = load_valid & load_ready. On the accepting edge:
  - shift register <= parallel_data_in;
  - bit count <= 0;
  - state <= SHIFT.
- Latency: the first bit (bit 0) appears on serial_data_out in the cycle after the accepting edge.
- In SHIFT:
  - serial_data_out = shift register[0], driven directly from the register (glitch-free); serial_valid = 1.
  - On each edge the register shifts right by one (MSB filled with 0) and bit count increments.
  - last_bit = (bit count == WIDTH-1).
- End of word, on the edge where bit count = WIDTH-1:
  - if accept: load the new word, bit count <= 0, stay in SHIFT. No gap, so serial_valid stays 1.
  - else: state <= IDLE.
  - In both cases done <= 1 for exactly one cycle.
- In IDLE: serial_data_out = IDLE_LEVEL, serial_valid = 0, last_bit = 0.
- load_valid while load_ready = 0 is ignored. The bench must hold the word until it is accepted.
- parallel_data_in is sampled only on the accepting edge. Later changes have no effect on the word in flight.
- Bit count width is $clog2(WIDTH); it never exceeds WIDTH-1.
- Reset mid-word: the word is abandoned, no done pulse is issued, and all outputs return to reset values.
- A word takes exactly WIDTH cycles of serial_valid. Sustained throughput is one word per WIDTH cycles.

Decomposition:
- Shared package holds:
  - the state type (IDLE, SHIFT) as a 1-bit enum;
  - a function returning the count width, $clog2(WIDTH) with a minimum of 1.
- No sub-module is needed. FSM, counter and shift register fit in one module of roughly 120-150 lines.

Test Plan:
1. Reset check: reset held high for 12 ns, then released -> load_ready=1, serial_valid=0, serial_data_out=0, done=0.
2. Single word: load 4'b1101 for one cycle -> serial bits 1,0,1,1 on four consecutive cycles with serial_valid=1; last_bit high on the 4th; done pulses the cycle after; return to IDLE.
3. Back-to-back: load 4'b1101, keep load_valid high with 4'b0110 ready at the last bit -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; done pulses twice, four cycles apart.
4. Ignored load: pulse load_valid with 4'b1111 during bit 1 of a 4'b0001 transfer -> load_ready=0, sequence stays 1,0,0,0, and 4'b1111 is never sent.
5. Reset mid-word: assert reset during bit 2 of 4'b1010 -> outputs clear immediately, no done pulse; the next load of 4'b0011 sends 1,1,0,0.
6. Loopback: drive serial_data_out into the shift-right SIPO, enabled by serial_valid -> after the 4th valid bit, SIPO parallel_data_out = 4'b1101.
